// File: rtl/tx_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its picker.
package tx_arb_pkg;

    // Upper bound on requesters any arbiter built on rr_picker is sized for.
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } tx_arb_state_t;

    // Round-robin distance of slot i from the last winner: 1 for the slot
    // right after last, n for last itself, so a smaller value wins.
    function automatic int rr_dist(input int i, input int last, input int n);
        return (i > last) ? (i - last) : (i - last + n);
    endfunction

endpackage

// File: rtl/tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request above `last`, wrapping.
module rr_picker
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               any,
    output logic [IDX_W-1:0]   winner
);

    // Keep the requester closest (in round-robin order) to the last winner.
    always_comb begin
        int best;
        int d;
        any    = 1'b0;
        winner = '0;
        best   = NUM_REQ + 1;
        d      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = rr_dist(i, int'(last), NUM_REQ);
            if (req[i] && d < best) begin
                best   = d;
                winner = IDX_W'(i);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte sources: round-robin grant,
// byte capture, and the full send/busy handshake with the transmitter.
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    input  logic                 odd_in,
    input  logic                 tx_busy,
    output logic                 tx_send,
    output logic [7:0]           tx_din,
    output logic                 tx_odd,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 active,
    output logic                 frame_done
);

    tx_arb_state_t    state;
    logic [IDX_W-1:0] last;
    logic             any;
    logic [IDX_W-1:0] winner;
    logic [7:0]       win_byte;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req_valid),
        .last   (last),
        .any    (any),
        .winner (winner)
    );

    // Select the winning requester's byte for capture.
    always_comb begin
        win_byte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == winner) begin
                win_byte = req_data[8*i +: 8];
            end
        end
    end

    // Grant/handshake sequencer. The transmitter has no reset, so a grant is
    // only made once it reports idle; requests are looked at only in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last       <= IDX_W'(NUM_REQ - 1);
            req_ack    <= '0;
            tx_send    <= 1'b0;
            tx_din     <= 8'h00;
            tx_odd     <= 1'b0;
            grant_idx  <= '0;
            active     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            req_ack    <= '0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (any && !tx_busy) begin
                        req_ack   <= NUM_REQ'(1) << winner;
                        grant_idx <= winner;
                        last      <= winner;
                        tx_din    <= win_byte;
                        tx_odd    <= odd_in;
                        tx_send   <= 1'b1;
                        active    <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    // Hold send and data until the transmitter has loaded.
                    if (tx_busy) begin
                        tx_send <= 1'b0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!tx_busy) begin
                        frame_done <= 1'b1;
                        active     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter (`tx`) among `NUM_REQ` byte sources. It captures one byte from the winning requester and drives the transmitter's `din`/`send`/`odd` inputs. It runs the full `send`/`busy` handshake so the transmitter always returns to idle before the next grant. It sits between the I/O-system byte producers (console, debug dump, status reporter) and the single `tx` instance driving the board's serial pin.

## Interface
- `NUM_REQ`, 4: number of requesters, legal range 2–8.
- `IDX_W`, `$clog2(NUM_REQ)`: width of the grant index; derived, do not override.
- `clk`  in  1: system clock; all logic on rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `req_valid`  in  NUM_REQ: bit i set means requester i holds a byte to send.
- `req_data`  in  8*NUM_REQ: byte i is `req_data[8*i+7:8*i]`.
- `req_ack`  out  NUM_REQ: one-hot, one-cycle pulse; byte i captured, requester may change data or drop valid.
- `odd_in`  in  1: parity mode; sampled together with the byte.
- `tx_busy`  in  1: `busy` from `tx`.
- `tx_send`  out  1: to `tx` `send`.
- `tx_din`  out  8: to `tx` `din`.
- `tx_odd`  out  1: to `tx` `odd`.
- `grant_idx`  out  IDX_W: index of the requester whose byte is in flight.
- `active`  out  1: high from capture until the frame completes.
- `frame_done`  out  1: one-cycle pulse when the transmitter returns to idle.

## Operation
The state machine has three states: IDLE, SEND and DRAIN.

- **IDLE:** if any `req_valid` is set and `tx_busy`=0:
  - pick the winner by round-robin, starting at `last+1` mod NUM_REQ and searching upward;
  - capture the winner's byte into `tx_din` and `odd_in` into `tx_odd`;
  - pulse `req_ack[w]`, set `grant_idx`=w, set `last`=w;
  - assert `tx_send` and `active`, then go to SEND.
- **IDLE with `tx_busy`=1:** this happens after a reset mid-frame, because `tx` has no reset. No grant is made until `tx_busy`=0.
- **SEND:** hold `tx_send`=1 and keep `tx_din`/`tx_odd` stable until `tx_busy`=1. Then clear `tx_send` and go to DRAIN.
- **DRAIN:** `tx_send`=0. When `tx_busy`=0:
  - pulse `frame_done`;
  - clear `active`;
  - go to IDLE.
- **Request rules:**
  - `req_valid` dropping before a grant cancels that request silently.
  - `req_valid` changes during SEND or DRAIN have no effect.
  - A requester that stays valid after its ack is treated as a new request.
- **Reset values:**
  - state = IDLE;
  - `tx_send`=0, `tx_din`=8'h00, `tx_odd`=0;
  - `req_ack`=0, `grant_idx`=0, `active`=0, `frame_done`=0;
  - `last`=NUM_REQ-1, so requester 0 has the highest priority first.
- **Reset mid-frame:** all outputs return to their reset values on the next edge. The next grant waits for `tx_busy` to fall.
- All outputs are registered.

## Timing
- **Cycle 0:** IDLE, `req_valid[w]`=1, `tx_busy`=0.
- **Cycle 1:** `req_ack[w]`=1 (this cycle only), `tx_send`=1, `tx_din` valid, `active`=1.
- **`tx` load:** `tx` loads at the end of cycle 1, and `tx_busy`=1 in cycle 2.
- **Send release:** `tx_send`=0 from cycle 3, the cycle after `tx_busy` is first seen high. This falls well inside `tx` COUNT, so `tx` WAIT exits immediately.
- **Frame end:** `tx_busy` falls in cycle F. Then `frame_done`=1 and `active`=0 in cycle F+1, and state is IDLE.
- **Back-to-back:** with a request pending, the next grant comes from IDLE in cycle F+1, so the next `req_ack` is in cycle F+2.
- **Throughput:** at most 4 overhead cycles per frame on top of the `tx` frame time.
- **Simultaneous events:** IDLE with all requesters valid grants w=(last+1) mod NUM_REQ. Ack and a new request from the same requester in the same cycle: the request is ignored until IDLE.

## Structure
- Package `tx_arb_pkg`:
  - state enum `tx_arb_state_t` {IDLE, SEND, DRAIN};
  - constant `MAX_REQ`=8.
- Sub-module `rr_picker`: purely combinational.
  - Inputs: `req` vector and `last` index.
  - Outputs: `any` and `winner` index.
  - Reusable by other shared I/O resources.
- Top level holds the FSM, the capture registers and the `last` pointer.
- The bench instantiates the real `tx` with `CLK_FREQUECY`=16 and `BAUD_RATE`=1, giving 16 cycles per bit.

## Test plan
- **Reset default:** after reset, `req_valid`=4'b0001 with `req_data[7:0]`=8'h55 and `odd_in`=0 -> `req_ack`=4'b0001 one cycle later; `tx_out` serializes start bit 0, bits 1,0,1,0,1,0,1,0 and parity 0; `frame_done` pulses once.
- **Round-robin rotation:** all four valid continuously with bytes 8'h10/11/12/13 -> grants in order 0,1,2,3,0; each `req_ack` is exactly one cycle.
- **Cancel before grant:** requester 2 valid, dropped while requester 1's frame is in DRAIN -> requester 2 is never acked; the next grant goes to the next valid requester.
- **Handshake protocol:** check that `tx_send` rises only when `tx_busy`=0, falls exactly 1 cycle after `tx_busy` rises, and that `tx_din` is stable while `tx_send`=1.
- **Reset mid-frame:** assert `rst_n`=0 for 1 cycle mid-frame with requester 3 valid -> no `req_ack` until `tx_busy`=0; then requester 3 (8'hA7, `odd_in`=1) is granted and the frame carries parity bit 0.
- **Back-to-back spacing:** two requesters valid -> the second `req_ack` arrives exactly 1 cycle after `frame_done` of the first.
